// File: rtl/reg_file_wb_pkg.sv
// Shared constants and register mnemonics for the
// register file with write-back buffer.
package reg_file_wb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [ADDR_W-1:0] {
      ZERO = 5'd0,
      AT   = 5'd1,
      V0   = 5'd2,
      SP   = 5'd29,
      RA   = 5'd31
   } reg_name_e;

endpackage

// File: rtl/reg_file_wb_read_bypass.sv
// One read port: zero register, pending-buffer bypass,
// otherwise the array word.
module reg_read_bypass #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              pend_valid,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic [DATA_W-1:0] pend_data,
   input  logic [DATA_W-1:0] arr_data,
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = arr_data;
      if (addr == '0) begin
         data = '0;
      end else if (pend_valid && (addr == pend_addr)) begin
         data = pend_data;
      end
   end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 register file; writes are posted in a one-entry
// buffer and committed on the following edge.
module reg_file_wb #(
   parameter int DATA_W = reg_file_wb_pkg::DATA_W,
   parameter int ADDR_W = reg_file_wb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              pend_valid
);

   import reg_file_wb_pkg::*;

   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;

   // Commit of the old entry and capture of the new one share an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
      end else begin
         if (pend_valid) begin
            regs[pend_addr] <= pend_data;
         end
         if (we && (waddr != REG_ZERO)) begin
            pend_valid <= 1'b1;
            pend_addr  <= waddr;
            pend_data  <= wdata;
         end else begin
            pend_valid <= 1'b0;
         end
      end
   end

   reg_read_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_a (
      .addr       (raddr_a),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr),
      .pend_data  (pend_data),
      .arr_data   (regs[raddr_a]),
      .data       (rdata_a)
   );

   reg_read_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_b (
      .addr       (raddr_b),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr),
      .pend_data  (pend_data),
      .arr_data   (regs[raddr_b]),
      .data       (rdata_b)
   );

   reg_read_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_dbg (
      .addr       (dbg_addr),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr),
      .pend_data  (pend_data),
      .arr_data   (regs[dbg_addr]),
      .data       (dbg_data)
   );

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed vector table plus
// hand-written reset and sweep sequences.
module tb_reg_file_wb;

   import reg_file_wb_pkg::*;

   logic              clk;
   logic              reset;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr_a;
   logic [ADDR_W-1:0] raddr_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              pend_valid;

   int n_checks;
   int n_fail;

   reg_file_wb dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .raddr_a    (raddr_a),
      .raddr_b    (raddr_b),
      .rdata_a    (rdata_a),
      .rdata_b    (rdata_b),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .pend_valid (pend_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rb;
      logic [ADDR_W-1:0] da;
      logic [DATA_W-1:0] ea;
      logic [DATA_W-1:0] eb;
      logic [DATA_W-1:0] ed;
      logic              epv;
   } vec_t;

   typedef struct {
      int                idx;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] d;
      logic              pv;
   } exp_t;

   vec_t vt [12];
   exp_t sbq [$];

   task automatic chk(input string name,
                      input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
   endtask

   initial begin
      exp_t e;
      n_checks = 0;
      n_fail   = 0;
      idle();
      raddr_a  = '0;
      raddr_b  = '0;
      dbg_addr = '0;

      // reset with a write pending on the inputs
      reset = 1'b1;
      we    = 1'b1;
      waddr = 5'd5;
      wdata = 32'hDEAD_BEEF;
      tick();
      tick();
      reset = 1'b0;
      idle();
      #1;
      chk("reset_pv", {31'd0, pend_valid}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         raddr_a  = 5'(i);
         raddr_b  = 5'(i);
         dbg_addr = 5'(i);
         #1;
         chk($sformatf("reset_a[%0d]", i), rdata_a, 32'd0);
         chk($sformatf("reset_b[%0d]", i), rdata_b, 32'd0);
         chk($sformatf("reset_d[%0d]", i), dbg_data, 32'd0);
      end

      // same-cycle read is not bypassed
      we      = 1'b1;
      waddr   = 5'd8;
      wdata   = 32'h1234_5678;
      raddr_a = 5'd8;
      #1;
      chk("pre_edge_a", rdata_a, 32'd0);

      vt[0]  = '{1'b1, 5'd8, 32'h1234_5678, 5'd8, 5'd0, 5'd8,
                 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1};
      vt[1]  = '{1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 5'd0,
                 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0};
      vt[2]  = '{1'b1, ZERO, 32'hFFFF_FFFF, ZERO, 5'd8, ZERO,
                 32'd0, 32'h1234_5678, 32'd0, 1'b0};
      vt[3]  = '{1'b0, 5'd0, 32'd0, ZERO, 5'd8, ZERO,
                 32'd0, 32'h1234_5678, 32'd0, 1'b0};
      vt[4]  = '{1'b1, AT, 32'd1, AT, V0, AT,
                 32'd1, 32'd0, 32'd1, 1'b1};
      vt[5]  = '{1'b1, V0, 32'd2, AT, V0, V0,
                 32'd1, 32'd2, 32'd2, 1'b1};
      vt[6]  = '{1'b1, AT, 32'd3, AT, V0, AT,
                 32'd3, 32'd2, 32'd3, 1'b1};
      vt[7]  = '{1'b0, 5'd0, 32'd0, AT, V0, AT,
                 32'd3, 32'd2, 32'd3, 1'b0};
      vt[8]  = '{1'b0, 5'd0, 32'd0, AT, V0, V0,
                 32'd3, 32'd2, 32'd2, 1'b0};
      vt[9]  = '{1'b1, SP, 32'h7FFF_FFF0, SP, RA, SP,
                 32'h7FFF_FFF0, 32'd0, 32'h7FFF_FFF0, 1'b1};
      vt[10] = '{1'b1, RA, 32'h0040_0010, SP, RA, RA,
                 32'h7FFF_FFF0, 32'h0040_0010, 32'h0040_0010, 1'b1};
      vt[11] = '{1'b0, 5'd0, 32'd0, SP, RA, 5'd8,
                 32'h7FFF_FFF0, 32'h0040_0010, 32'h1234_5678, 1'b0};

      for (int i = 0; i < 12; i++) begin
         we       = vt[i].we;
         waddr    = vt[i].waddr;
         wdata    = vt[i].wdata;
         raddr_a  = vt[i].ra;
         raddr_b  = vt[i].rb;
         dbg_addr = vt[i].da;
         sbq.push_back('{i, vt[i].ea, vt[i].eb, vt[i].ed, vt[i].epv});
         tick();
         e = sbq.pop_front();
         chk($sformatf("vec%0d_a", e.idx), rdata_a, e.a);
         chk($sformatf("vec%0d_b", e.idx), rdata_b, e.b);
         chk($sformatf("vec%0d_d", e.idx), dbg_data, e.d);
         chk($sformatf("vec%0d_pv", e.idx), {31'd0, pend_valid},
             {31'd0, e.pv});
      end

      // reset while r9 is still in the buffer
      we      = 1'b1;
      waddr   = 5'd9;
      wdata   = 32'hA5A5_A5A5;
      raddr_a = 5'd9;
      raddr_b = 5'd8;
      tick();
      chk("midrst_buf_a", rdata_a, 32'hA5A5_A5A5);
      chk("midrst_buf_pv", {31'd0, pend_valid}, 32'd1);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_a", rdata_a, 32'd0);
      chk("midrst_r8", rdata_b, 32'd0);
      chk("midrst_pv", {31'd0, pend_valid}, 32'd0);
      tick();
      chk("midrst_a_late", rdata_a, 32'd0);

      // back-to-back sweep r(i) = i*4
      for (int i = 1; i < 32; i++) begin
         we    = 1'b1;
         waddr = 5'(i);
         wdata = 32'(i * 4);
         tick();
         chk($sformatf("sweep_pv%0d", i), {31'd0, pend_valid}, 32'd1);
      end
      idle();
      tick();
      chk("sweep_pv_idle", {31'd0, pend_valid}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         chk($sformatf("sweep_d[%0d]", i), dbg_data, 32'(i * 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
